vec_fifo_reader: RTL and testbench
==================================

VEC_FIFO_READER -- requirements
Module: vec_fifo_reader

Interface
REQ-001 SHALL have parameter VecElements, default 4, bytes per vector.
REQ-002 SHALL have parameter BytesPerWrite, default 1, bytes per writer beat.
REQ-003 SHALL have parameter BytesPerRead, default 2, bytes per output beat; VecElements divisible by BytesPerRead.
REQ-004 SHALL have parameter Depth, default 2, vector capacity of the attached FIFO.
REQ-005 SHALL have parameter Passes, default 3, number of times each vector is streamed (>=1).
REQ-006 SHALL have ports: clk_in  in  1  the single clock; rst_in  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: wr_valid_in  in  1  writer has a beat; wr_ready_out  out  1  beat accepted when both high.
REQ-008 SHALL have ports: fifo_wr_en_out  out  1  = wr_valid_in & wr_ready_out; fifo_rst_out  out  1  active-high FIFO reset.
REQ-009 SHALL have ports: fifo_rd_en_out  out  1  advance read pointer; fifo_wrap_rd_out  out  1  rewind to vector start.
REQ-010 SHALL have ports: fifo_rd_data_in  in  BytesPerRead x NBits  combinational FIFO read data.
REQ-011 SHALL have ports: m_valid_out  out  1; m_ready_in  in  1; m_data_out  out  BytesPerRead x NBits; m_last_out  out  1  last beat of a pass; m_final_out  out  1  last beat of the final pass.
REQ-012 SHALL have port vec_count_out  out  16  completed-vector count (see Configuration).

Function
REQ-013 SHALL track occupancy occ in bytes (width clog2(Depth*VecElements+1)); +BytesPerWrite per accepted write, -VecElements per retired vector, both applied in the same cycle when simultaneous.
REQ-014 SHALL drive wr_ready_out = (occ + BytesPerWrite <= Depth*VecElements), combinationally from occ, deasserted while fifo_rst_out is high.
REQ-015 SHALL implement FSM IDLE/STREAM: IDLE->STREAM when occ >= VecElements; STREAM->IDLE after the final beat of the final pass when occ - VecElements (post-update) < VecElements, else remain in STREAM.
REQ-016 SHALL issue a beat in STREAM when (!m_valid_out | m_ready_in): register fifo_rd_data_in into m_data_out, set m_valid_out, pulse exactly one of fifo_rd_en_out/fifo_wrap_rd_out.
REQ-017 SHALL pulse fifo_wrap_rd_out (not fifo_rd_en_out) on the last beat of every non-final pass; fifo_rd_en_out on all other beats.
REQ-018 SHALL maintain beat_cnt 0..VecElements/BytesPerRead-1 and pass_cnt 0..Passes-1, wrapping both to 0 after the final beat; retire the vector (occ decrement) in that cycle.
REQ-019 SHALL register m_last_out and m_final_out alongside m_data_out; m_final_out implies m_last_out.
REQ-020 SHALL hold m_data_out/m_last_out/m_final_out stable while m_valid_out & !m_ready_in, and clear m_valid_out on acceptance with no new beat issued.
REQ-021 SHALL sustain one beat per cycle with m_ready_in held high; first m_valid_out one cycle after IDLE->STREAM.
REQ-022 SHALL never issue a beat for a vector not fully written (occ < VecElements).

Reset
REQ-023 SHALL, while rst_in low, asynchronously force: state IDLE, occ/beat_cnt/pass_cnt 0, m_valid_out/m_last_out/m_final_out/fifo_rd_en_out/fifo_wrap_rd_out 0, m_data_out 0, vec_count_out 0.
REQ-024 SHALL hold fifo_rst_out high while rst_in low and for exactly one clk_in cycle after release; wr_ready_out low throughout.
REQ-025 SHALL discard any partially streamed vector on mid-operation reset; no beat after reset until a full new vector is written.

Configuration
REQ-026 SHALL, with VEC_FIFO_RD_STATS_EN defined, increment vec_count_out (wrapping at 16 bits) on each retired vector.
REQ-027 SHALL, without VEC_FIFO_RD_STATS_EN, tie vec_count_out to 0 and instantiate no counter.

Structure
REQ-028 SHALL take NBits (8) and the FSM state enum from the shared interface package.
REQ-029 SHALL contain one sub-module, vec_fifo_occ, holding occ and the wr_ready_out logic.

Verification (defaults)
REQ-030 Write 4 bytes, m_ready_in high -> 6 beats, m_last_out on beats 2/4/6, m_final_out on beat 6 only, wrap pulses after beats 2 and 4, data order B0B1,B2B3 repeated x3.
REQ-031 Write 8 bytes back-to-back -> wr_ready_out low at occ=8; 12 consecutive beats, no IDLE gap; occ returns to 0.
REQ-032 m_ready_in low 3 cycles mid-pass -> m_data_out stable, no fifo_rd_en_out/fifo_wrap_rd_out pulse during stall.
REQ-033 Write 3 bytes only -> m_valid_out stays 0; 4th byte -> m_valid_out one cycle after STREAM entry.
REQ-034 rst_in low during pass 2 -> all outputs per REQ-023, fifo_rst_out high one cycle after release, next stream starts at pass 0 beat 0.
REQ-035 With VEC_FIFO_RD_STATS_EN, 3 vectors streamed -> vec_count_out = 3; without it -> 0.

Source files
------------

// File: rtl/vec_fifo_reader_pkg.sv
// Shared definitions for the vector FIFO reader.
//   NBits      : width of one data byte lane
//   rd_state_e : reader FSM state encoding
//   cnt_w()    : counter width helper that never returns 0
package vec_fifo_reader_pkg;

  localparam int NBits = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_fifo_occ.sv
// Byte-occupancy tracker for the FIFO in front of the reader.
// Ports:
//   clk_in, rst_in : clock, async active-low reset
//   blk            : FIFO is being reset, refuse writes
//   wr_valid       : writer offers a beat
//   retire         : a whole vector leaves the FIFO this cycle
//   wr_ready       : room for one more writer beat
//   wr_en          : writer beat accepted this cycle
//   occ / occ_nxt  : current and post-update occupancy in bytes
module vec_fifo_occ #(
  parameter int VecElements   = 4,
  parameter int BytesPerWrite = 1,
  parameter int Depth         = 2,
  parameter int OccW          = $clog2(Depth*VecElements+1)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            blk,
  input  logic            wr_valid,
  input  logic            retire,
  output logic            wr_ready,
  output logic            wr_en,
  output logic [OccW-1:0] occ,
  output logic [OccW-1:0] occ_nxt
);

  localparam int Cap = Depth * VecElements;

  // Compare in 32 bits so occ + BytesPerWrite cannot wrap.
  assign wr_ready = !blk && ((32'(occ) + 32'(BytesPerWrite)) <= 32'(Cap));
  assign wr_en    = wr_valid && wr_ready;

  // Write and retire may land in the same cycle; both apply.
  assign occ_nxt = occ + (wr_en  ? OccW'(BytesPerWrite) : '0)
                       - (retire ? OccW'(VecElements)   : '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) occ <= '0;
    else         occ <= occ_nxt;
  end

endmodule

// File: rtl/vec_fifo_reader.sv
// Streams each complete vector from an attached FIFO Passes times.
// Each output beat carries BytesPerRead bytes. Non-final passes end with a
// rewind pulse so the FIFO replays the same vector. The last beat of the
// final pass advances past the vector and retires it.
// Optional feature: define VEC_FIFO_RD_STATS_EN to count retired vectors on
// vec_count_out. Without it, vec_count_out is tied to 0.
// Ports:
//   clk_in, rst_in             : clock, async active-low reset
//   wr_valid_in / wr_ready_out : writer handshake (FIFO writes are external)
//   fifo_wr_en_out             : accepted writer beat
//   fifo_rst_out               : active-high FIFO reset (reset + 1 cycle)
//   fifo_rd_en_out             : advance FIFO read pointer by one beat
//   fifo_wrap_rd_out           : rewind FIFO read pointer to vector start
//   fifo_rd_data_in            : combinational FIFO read data
//   m_valid_out/m_ready_in     : output handshake
//   m_data_out                 : output beat
//   m_last_out                 : last beat of a pass
//   m_final_out                : last beat of the final pass
//   vec_count_out              : retired-vector count (stats build only)
module vec_fifo_reader
  import vec_fifo_reader_pkg::*;
#(
  parameter int VecElements   = 4,
  parameter int BytesPerWrite = 1,
  parameter int BytesPerRead  = 2,
  parameter int Depth         = 2,
  parameter int Passes        = 3
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 wr_valid_in,
  output logic                                 wr_ready_out,
  output logic                                 fifo_wr_en_out,
  output logic                                 fifo_rst_out,
  output logic                                 fifo_rd_en_out,
  output logic                                 fifo_wrap_rd_out,
  input  logic [BytesPerRead-1:0][NBits-1:0]   fifo_rd_data_in,
  output logic                                 m_valid_out,
  input  logic                                 m_ready_in,
  output logic [BytesPerRead-1:0][NBits-1:0]   m_data_out,
  output logic                                 m_last_out,
  output logic                                 m_final_out,
  output logic [15:0]                          vec_count_out
);

  localparam int Beats = VecElements / BytesPerRead;
  localparam int BeatW = cnt_w(Beats);
  localparam int PassW = cnt_w(Passes);
  localparam int OccW  = $clog2(Depth*VecElements+1);

  rd_state_e        state, state_nxt;
  logic [BeatW-1:0] beat_cnt;
  logic [PassW-1:0] pass_cnt;
  logic [OccW-1:0]  occ, occ_nxt;
  logic [1:0]       frst_sr;
  logic             occ_ge_vec, last_beat, final_pass, issue, retire;

  // Two-stage shift register: fifo_rst_out stays high through the first
  // clock edge after release, then drops.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) frst_sr <= 2'b11;
    else         frst_sr <= {frst_sr[0], 1'b0};
  end
  assign fifo_rst_out = frst_sr[1];

  vec_fifo_occ #(
    .VecElements  (VecElements),
    .BytesPerWrite(BytesPerWrite),
    .Depth        (Depth),
    .OccW         (OccW)
  ) u_occ (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .blk     (fifo_rst_out),
    .wr_valid(wr_valid_in),
    .retire  (retire),
    .wr_ready(wr_ready_out),
    .wr_en   (fifo_wr_en_out),
    .occ     (occ),
    .occ_nxt (occ_nxt)
  );

  assign occ_ge_vec = (occ >= OccW'(VecElements));
  assign last_beat  = (beat_cnt == BeatW'(Beats-1));
  assign final_pass = (pass_cnt == PassW'(Passes-1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // A beat goes out only for a fully written vector and only when the
  // output register is empty or being drained this cycle.
  always_comb begin
    state_nxt        = state;
    issue            = 1'b0;
    retire           = 1'b0;
    fifo_rd_en_out   = 1'b0;
    fifo_wrap_rd_out = 1'b0;
    case (state)
      IDLE: begin
        if (occ_ge_vec) state_nxt = STREAM;
      end
      STREAM: begin
        issue            = occ_ge_vec && (!m_valid_out || m_ready_in);
        retire           = issue && last_beat && final_pass;
        fifo_wrap_rd_out = issue && last_beat && !final_pass;
        fifo_rd_en_out   = issue && !(last_beat && !final_pass);
        // Stay in STREAM when another full vector is already waiting.
        if (retire && (occ_nxt < OccW'(VecElements))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      beat_cnt <= '0;
      pass_cnt <= '0;
    end else if (issue) begin
      if (last_beat) begin
        beat_cnt <= '0;
        pass_cnt <= final_pass ? '0 : pass_cnt + PassW'(1);
      end else begin
        beat_cnt <= beat_cnt + BeatW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_valid_out <= 1'b0;
      m_data_out  <= '0;
      m_last_out  <= 1'b0;
      m_final_out <= 1'b0;
    end else if (issue) begin
      m_valid_out <= 1'b1;
      m_data_out  <= fifo_rd_data_in;
      m_last_out  <= last_beat;
      m_final_out <= last_beat && final_pass;
    end else if (m_ready_in) begin
      m_valid_out <= 1'b0;
    end
  end

`ifdef VEC_FIFO_RD_STATS_EN
  logic [15:0] vec_cnt;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     vec_cnt <= '0;
    else if (retire) vec_cnt <= vec_cnt + 16'd1;
  end
  assign vec_count_out = vec_cnt;
`else
  assign vec_count_out = '0;
`endif

endmodule

// File: tb/tb_vec_fifo_reader.sv
module tb_vec_fifo_reader;

  localparam int VE = 4, BPW = 1, BPR = 2, DEPTH = 2, PASSES = 3;
  localparam int CAP = DEPTH * VE, BEATS = VE / BPR;

  typedef struct packed {
    logic                   last;
    logic                   fin;
    logic [BPR-1:0][7:0]    data;
  } beat_t;

  logic clk_in = 0, rst_in = 0;
  logic wr_valid_in = 0, wr_ready_out, fifo_wr_en_out, fifo_rst_out;
  logic fifo_rd_en_out, fifo_wrap_rd_out;
  logic [BPR-1:0][7:0] fifo_rd_data_in, m_data_out;
  logic m_valid_out, m_ready_in = 1, m_last_out, m_final_out;
  logic [15:0] vec_count_out;
  logic [7:0] wr_data = 0;

  int checks = 0, passed = 0;
  int beats_seen = 0, wraps_seen = 0, rds_seen = 0;
  beat_t sb_q[$];
  logic [7:0] vbuf[$];

  always #5 clk_in = ~clk_in;

  vec_fifo_reader #(.VecElements(VE), .BytesPerWrite(BPW), .BytesPerRead(BPR),
                    .Depth(DEPTH), .Passes(PASSES)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_valid_in(wr_valid_in),
    .wr_ready_out(wr_ready_out), .fifo_wr_en_out(fifo_wr_en_out),
    .fifo_rst_out(fifo_rst_out), .fifo_rd_en_out(fifo_rd_en_out),
    .fifo_wrap_rd_out(fifo_wrap_rd_out), .fifo_rd_data_in(fifo_rd_data_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out),
    .m_last_out(m_last_out), .m_final_out(m_final_out), .vec_count_out(vec_count_out));

  // Behavioural FIFO attached to the reader.
  logic [7:0] mem [CAP];
  int wp = 0, rp = 0;
  always @(posedge clk_in) begin
    if (fifo_rst_out) begin
      wp <= 0; rp <= 0;
    end else begin
      if (fifo_wr_en_out) begin mem[wp] <= wr_data; wp <= (wp + 1) % CAP; end
      if (fifo_rd_en_out)        rp <= (rp + BPR) % CAP;
      else if (fifo_wrap_rd_out) rp <= (rp + CAP + BPR - VE) % CAP;
    end
  end
  always_comb begin
    fifo_rd_data_in = '0;
    for (int i = 0; i < BPR; i++) fifo_rd_data_in[i] = mem[(rp + i) % CAP];
  end

  // Scoreboard: pop and compare each accepted output beat.
  always @(negedge clk_in) begin
    beat_t obs, exp;
    if (rst_in) begin
      if (fifo_wrap_rd_out) wraps_seen++;
      if (fifo_rd_en_out)   rds_seen++;
      if (m_valid_out && m_ready_in) begin
        beats_seen++;
        checks++;
        obs.last = m_last_out; obs.fin = m_final_out; obs.data = m_data_out;
        if (sb_q.size() == 0)
          $display("FAIL sb_unexpected_beat got %h want none", obs);
        else begin
          exp = sb_q.pop_front();
          if (obs !== exp) $display("FAIL sb_beat got %h want %h", obs, exp);
          else passed++;
        end
      end
    end
  end

  function automatic void push_expect();
    beat_t b;
    for (int p = 0; p < PASSES; p++)
      for (int k = 0; k < BEATS; k++) begin
        for (int i = 0; i < BPR; i++) b.data[i] = vbuf[k*BPR + i];
        b.last = (k == BEATS-1);
        b.fin  = (k == BEATS-1) && (p == PASSES-1);
        sb_q.push_back(b);
      end
    vbuf.delete();
  endfunction

  // Drives n writer beats; returns at posedge+1 after the last acceptance.
  task automatic push_bytes(input int n);
    int sent = 0, g = 0;
    logic acc;
    @(posedge clk_in); #1;
    wr_data = 8'($urandom);
    while (sent < n && g < 200) begin
      wr_valid_in = 1;
      @(negedge clk_in); acc = wr_ready_out;
      @(posedge clk_in); #1;
      if (acc) begin
        vbuf.push_back(wr_data);
        sent++;
        if (vbuf.size() == VE) push_expect();
        wr_data = 8'($urandom);
      end
      g++;
    end
    wr_valid_in = 0;
    if (sent < n) begin checks++; $display("FAIL push_timeout got %0d want %0d", sent, n); end
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    do begin @(negedge clk_in); #1; g++; end
    while ((sb_q.size() != 0 || m_valid_out) && g < 300);
    checks++;
    if (sb_q.size() != 0 || m_valid_out)
      $display("FAIL drain_%s got %0d pending want 0", nm, sb_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk_in); #1;
    checks++;
    if ({m_valid_out, m_last_out, m_final_out, fifo_rd_en_out, fifo_wrap_rd_out} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000",
               {m_valid_out, m_last_out, m_final_out, fifo_rd_en_out, fifo_wrap_rd_out});
    else passed++;
    checks++;
    if ({m_data_out, vec_count_out} !== '0) $display("FAIL reset_data got %h want 0", {m_data_out, vec_count_out});
    else passed++;
    checks++;
    if ({fifo_rst_out, wr_ready_out} !== 2'b10) $display("FAIL reset_fifo_rst got %b want 10", {fifo_rst_out, wr_ready_out});
    else passed++;
    @(posedge clk_in); #1 rst_in = 1;
    @(posedge clk_in); @(negedge clk_in);
    checks++;
    if ({fifo_rst_out, wr_ready_out} !== 2'b10) $display("FAIL rel_cycle1 got %b want 10", {fifo_rst_out, wr_ready_out});
    else passed++;
    @(negedge clk_in);
    checks++;
    if ({fifo_rst_out, wr_ready_out} !== 2'b01) $display("FAIL rel_cycle2 got %b want 01", {fifo_rst_out, wr_ready_out});
    else passed++;
  endtask

  task automatic test_single_vector();
    int b0 = beats_seen, w0 = wraps_seen, r0 = rds_seen;
    m_ready_in = 1;
    push_bytes(4);
    wait_drain("single");
    checks++;
    if (beats_seen - b0 != 6) $display("FAIL single_beats got %0d want 6", beats_seen - b0); else passed++;
    checks++;
    if (wraps_seen - w0 != 2) $display("FAIL single_wraps got %0d want 2", wraps_seen - w0); else passed++;
    checks++;
    if (rds_seen - r0 != 4) $display("FAIL single_rd_en got %0d want 4", rds_seen - r0); else passed++;
  endtask

  task automatic test_back_to_back();
    int g = 0;
    bit ok = 1;
    m_ready_in = 1;
    fork
      begin
        push_bytes(8);
        @(negedge clk_in);
        checks++;
        if (wr_ready_out !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", wr_ready_out);
        else passed++;
      end
      begin
        while (!m_valid_out && g < 60) begin @(negedge clk_in); #1; g++; end
        for (int i = 1; i < 12; i++) begin
          @(negedge clk_in); #1;
          if (!m_valid_out) ok = 0;
        end
        checks++;
        if (!ok || g >= 60) $display("FAIL b2b_consecutive got gap want 12 beats");
        else passed++;
        @(negedge clk_in); #1;
        checks++;
        if (m_valid_out !== 1'b0) $display("FAIL b2b_end got %b want 0", m_valid_out);
        else passed++;
      end
    join
    wait_drain("b2b");
    checks++;
    if (u_dut.occ !== '0) $display("FAIL b2b_occ got %0d want 0", u_dut.occ); else passed++;
  endtask

  task automatic test_stall();
    int g = 0;
    m_ready_in = 1;
    push_bytes(4);
    while (!m_valid_out && g < 20) begin @(negedge clk_in); #1; g++; end
    @(posedge clk_in); #1 m_ready_in = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in); #1;
      checks++;
      if (!m_valid_out || m_data_out !== sb_q[0].data || fifo_rd_en_out || fifo_wrap_rd_out)
        $display("FAIL stall_hold got v%b d%h rd%b wr%b want v1 d%h rd0 wr0",
                 m_valid_out, m_data_out, fifo_rd_en_out, fifo_wrap_rd_out, sb_q[0].data);
      else passed++;
    end
    @(posedge clk_in); #1 m_ready_in = 1;
    wait_drain("stall");
  endtask

  task automatic test_partial();
    bit ok = 1;
    push_bytes(3);
    for (int i = 0; i < 6; i++) begin @(negedge clk_in); if (m_valid_out) ok = 0; end
    checks++;
    if (!ok) $display("FAIL partial_no_beat got valid want 0"); else passed++;
    push_bytes(1);
    @(negedge clk_in); @(negedge clk_in);
    checks++;
    if (m_valid_out !== 1'b0) $display("FAIL partial_early got %b want 0", m_valid_out); else passed++;
    @(negedge clk_in);
    checks++;
    if (m_valid_out !== 1'b1) $display("FAIL partial_first got %b want 1", m_valid_out); else passed++;
    wait_drain("partial");
  endtask

  task automatic test_reset_mid();
    int b0 = beats_seen, g = 0;
    bit ok = 1;
    m_ready_in = 1;
    push_bytes(4);
    while (beats_seen - b0 < 3 && g < 40) begin @(negedge clk_in); #1; g++; end
    rst_in = 0;
    sb_q.delete(); vbuf.delete();
    #1;
    checks++;
    if ({m_valid_out, m_last_out, m_final_out, fifo_rd_en_out, fifo_wrap_rd_out, fifo_rst_out, wr_ready_out} !== 7'b0000010)
      $display("FAIL midrst_ctrl got %b want 0000010",
               {m_valid_out, m_last_out, m_final_out, fifo_rd_en_out, fifo_wrap_rd_out, fifo_rst_out, wr_ready_out});
    else passed++;
    checks++;
    if ({m_data_out, vec_count_out} !== '0) $display("FAIL midrst_data got %h want 0", {m_data_out, vec_count_out});
    else passed++;
    @(posedge clk_in); @(posedge clk_in); #1 rst_in = 1;
    @(posedge clk_in); @(negedge clk_in);
    checks++;
    if (fifo_rst_out !== 1'b1) $display("FAIL midrst_rel1 got %b want 1", fifo_rst_out); else passed++;
    @(negedge clk_in);
    checks++;
    if (fifo_rst_out !== 1'b0) $display("FAIL midrst_rel2 got %b want 0", fifo_rst_out); else passed++;
    for (int i = 0; i < 4; i++) begin @(negedge clk_in); if (m_valid_out) ok = 0; end
    checks++;
    if (!ok) $display("FAIL midrst_stale_beat got valid want 0"); else passed++;
    push_bytes(4);
    wait_drain("midrst");
  endtask

  task automatic test_stats();
    logic [15:0] want;
`ifdef VEC_FIFO_RD_STATS_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    push_bytes(8);
    wait_drain("stats");
    checks++;
    if (vec_count_out !== want) $display("FAIL vec_count got %0d want %0d", vec_count_out, want);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_to_back();
    test_stall();
    test_partial();
    test_reset_mid();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
